// File: rtl/rv32_ram_responder.sv
// Memory-side responder for rv32_core: word RAM with async read, byte-strobed writes, program
// loader that holds the core in reset, and a TOHOST FIFO. Optional checksum loader: RAM_LOAD_CHECKSUM_EN.
module rv32_ram_responder #(
  parameter int                    ADDR_WIDTH  = 16,
  parameter logic [31:0]           START_ADDR  = 32'h10000,
  parameter logic [ADDR_WIDTH-1:0] TOHOST_WORD = 16'hFFFF,
  parameter int                    FIFO_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ram_wr_en,
  input  logic [3:0]            ram_wr_strobe,
  input  logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [31:0]           ram_data_in,
  output logic [31:0]           ram_data_out,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [31:0]           ld_data,
  input  logic                  ld_last,
  output logic                  core_reset_n,
  output logic                  tohost_valid,
  input  logic                  tohost_ready,
  output logic [31:0]           tohost_data,
  output logic                  tohost_ovf,
  output logic                  done,
  output logic [30:0]           exit_code,
  output logic                  load_err,
  output logic [1:0]            dbg_state
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LOAD_BASE = START_ADDR[ADDR_WIDTH+1:2];

`ifdef RAM_LOAD_CHECKSUM_EN
  typedef enum logic [1:0] {ST_LOAD = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2, ST_ERR = 2'd3} state_t;
`else
  typedef enum logic [1:0] {ST_LOAD = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_t;
`endif

  // Handshakes: a load beat transfers on a rising edge where ld_valid && ld_ready;
  // a tohost entry is popped on a rising edge where tohost_valid && tohost_ready.
  state_t                state, state_nx;
  logic [31:0]           mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] ld_ptr;
  logic [31:0]           fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]         rd_ptr, wr_ptr;
  logic [PW:0]           count;
  logic                  ld_fire, ld_write, core_write, push_req, push_ok, pop, fifo_full;

  assign ram_data_out = mem[ram_addr];
  assign ld_ready     = (state == ST_LOAD);
  assign ld_fire      = ld_valid && ld_ready;
  assign core_write   = ram_wr_en && (state == ST_RUN);
  assign push_req     = core_write && (ram_addr == TOHOST_WORD) && (ram_wr_strobe == 4'hF);
  assign fifo_full    = (count == (PW+1)'(FIFO_DEPTH));
  assign pop          = tohost_valid && tohost_ready;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok      = push_req && (!fifo_full || pop);
  assign tohost_valid = (count != '0);
  assign tohost_data  = fifo_mem[rd_ptr];
  assign done         = (state == ST_DONE);
  assign dbg_state    = state;

`ifdef RAM_LOAD_CHECKSUM_EN
  logic [31:0] ld_sum;
  // The final beat carries the checksum and is never stored.
  assign ld_write = ld_fire && !ld_last;
  assign load_err = (state == ST_ERR);

  always_ff @(posedge clk) begin
    if (!reset_n)      ld_sum <= '0;
    else if (ld_write) ld_sum <= ld_sum + ld_data;
  end
`else
  assign ld_write = ld_fire;
  assign load_err = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      ST_LOAD: begin
        if (ld_fire && ld_last) begin
`ifdef RAM_LOAD_CHECKSUM_EN
          state_nx = (ld_data == ld_sum) ? ST_RUN : ST_ERR;
`else
          state_nx = ST_RUN;
`endif
        end
      end
      ST_RUN:  if (push_ok && ram_data_in[0]) state_nx = ST_DONE;
      default: state_nx = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= ST_LOAD;
      core_reset_n <= 1'b0;
      ld_ptr       <= LOAD_BASE;
      exit_code    <= '0;
    end else begin
      state        <= state_nx;
      core_reset_n <= (state_nx == ST_RUN);
      if (ld_fire) ld_ptr <= ld_ptr + 1'b1;
      if (push_ok && ram_data_in[0]) exit_code <= ram_data_in[31:1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      if (ld_write) begin
        mem[ld_ptr] <= ld_data;
      end else if (core_write) begin
        for (int i = 0; i < 4; i++)
          if (ram_wr_strobe[i]) mem[ram_addr][8*i +: 8] <= ram_data_in[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      tohost_ovf <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{PW{1'b0}}, push_ok} - {{PW{1'b0}}, pop};
      if (push_req && !push_ok) tohost_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= ram_data_in;
  end

endmodule

// File: tb/tb_rv32_ram_responder.sv
// Self-checking bench for rv32_ram_responder: randomized loads, strobed writes and tohost traffic
// checked against a queue/associative-array reference model.
module tb_rv32_ram_responder;

  localparam logic [15:0] TOHOST = 16'hFFFF;
  localparam logic [15:0] BASE   = 16'h4000;
  localparam int          DEPTH  = 4;

  logic        clk, reset_n;
  logic        ram_wr_en;
  logic [3:0]  ram_wr_strobe;
  logic [15:0] ram_addr;
  logic [31:0] ram_data_in, ram_data_out;
  logic        ld_valid, ld_ready, ld_last;
  logic [31:0] ld_data;
  logic        core_reset_n, tohost_valid, tohost_ready, tohost_ovf, done, load_err;
  logic [31:0] tohost_data;
  logic [30:0] exit_code;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_q[$];
  logic [31:0] mem_model [int];
  logic [31:0] load_q[$];
  logic [15:0] ptr_model;
  bit          model_run, model_done, exp_ovf;
  logic [30:0] exp_exit;

  rv32_ram_responder dut (
    .clk(clk), .reset_n(reset_n),
    .ram_wr_en(ram_wr_en), .ram_wr_strobe(ram_wr_strobe), .ram_addr(ram_addr),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
    .core_reset_n(core_reset_n), .tohost_valid(tohost_valid), .tohost_ready(tohost_ready),
    .tohost_data(tohost_data), .tohost_ovf(tohost_ovf), .done(done),
    .exit_code(exit_code), .load_err(load_err), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ram_wr_en = 1'b0; ram_wr_strobe = 4'h0; ram_addr = '0; ram_data_in = '0;
    ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0; tohost_ready = 1'b0;
  endtask

  function automatic void model_reset();
    exp_q.delete();
    exp_ovf = 0; model_run = 0; model_done = 0; exp_exit = '0;
    ptr_model = BASE;
  endfunction

  // image of n random words; with the checksum loader the last beat is the sum
  task automatic build_image(input int n);
    logic [31:0] w, sum;
    load_q.delete();
    sum = '0;
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      load_q.push_back(w);
      sum = sum + w;
    end
`ifdef RAM_LOAD_CHECKSUM_EN
    load_q.push_back(sum);
`endif
  endtask

  // drivers
  task automatic core_write(input logic [15:0] a, input logic [3:0] s, input logic [31:0] d);
    logic [31:0] w;
    ram_wr_en = 1'b1; ram_addr = a; ram_wr_strobe = s; ram_data_in = d;
    tick();
    ram_wr_en = 1'b0;
    if (model_run) begin
      if (mem_model.exists(int'(a))) begin
        w = mem_model[int'(a)];
        for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
        mem_model[int'(a)] = w;
      end else if (s == 4'hF) begin
        mem_model[int'(a)] = d;
      end
    end
  endtask

  task automatic load_image();
    int gap;
    bit last;
    for (int i = 0; i < load_q.size(); i++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        ld_valid = 1'b0;
        ram_wr_en = 1'b1; ram_wr_strobe = 4'hF;
        ram_addr = 16'($urandom_range(0, 16'h03FF)); ram_data_in = $urandom;
        #1;
        n_cmp++;
        if ({ld_ready, core_reset_n} !== 2'b10) begin
          n_err++; $display("FAIL load_gap: ld_ready,core_reset_n=%b want 10", {ld_ready, core_reset_n});
        end
        tick();
      end
      last = (i == load_q.size() - 1);
      ram_wr_en = 1'b0; ld_valid = 1'b1; ld_data = load_q[i]; ld_last = last;
      #1;
      n_cmp++;
      if ({ld_ready, core_reset_n} !== 2'b10) begin
        n_err++; $display("FAIL load_beat: ld_ready,core_reset_n=%b want 10", {ld_ready, core_reset_n});
      end
      tick();
`ifdef RAM_LOAD_CHECKSUM_EN
      if (!last) mem_model[int'(ptr_model)] = load_q[i];
`else
      mem_model[int'(ptr_model)] = load_q[i];
`endif
      ptr_model = ptr_model + 16'd1;
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    model_run = 1;
    n_cmp++;
    if ({core_reset_n, ld_ready, load_err} !== 3'b100) begin
      n_err++; $display("FAIL load_to_run: core_reset_n,ld_ready,load_err=%b want 100",
                        {core_reset_n, ld_ready, load_err});
    end
  endtask

  task automatic verify_mem(input string tag);
    ram_wr_en = 1'b0; tohost_ready = 1'b0;
    foreach (mem_model[a]) begin
      ram_addr = 16'(a);
      #1;
      n_cmp++;
      if (ram_data_out !== mem_model[a]) begin
        n_err++; $display("FAIL mem_%s[%h]: got %h want %h", tag, a, ram_data_out, mem_model[a]);
      end
    end
    tick();
  endtask

  // one cycle of tohost traffic, checked against the queue model; scoreboard is exp_q
  task automatic fifo_cycle(input bit do_push, input logic [31:0] val, input bit rdy);
    bit pop, ok;
    ram_wr_en = do_push; ram_addr = TOHOST; ram_wr_strobe = 4'hF; ram_data_in = val;
    tohost_ready = rdy;
    #1;
    n_cmp++;
    if (tohost_valid !== (exp_q.size() != 0)) begin
      n_err++; $display("FAIL tohost_valid: got %b want %0d", tohost_valid, exp_q.size() != 0);
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      if (tohost_data !== exp_q[0]) begin
        n_err++; $display("FAIL tohost_head: got %h want %h", tohost_data, exp_q[0]);
      end
    end
    n_cmp++;
    if ({tohost_ovf, done, core_reset_n, load_err} !== {exp_ovf, model_done, model_run, 1'b0}) begin
      n_err++; $display("FAIL flags: ovf,done,core_reset_n,load_err=%b want %b",
                        {tohost_ovf, done, core_reset_n, load_err}, {exp_ovf, model_done, model_run, 1'b0});
    end
    n_cmp++;
    if (exit_code !== exp_exit) begin
      n_err++; $display("FAIL exit_code: got %h want %h", exit_code, exp_exit);
    end
    pop = (exp_q.size() != 0) && rdy;
    ok  = do_push && model_run && ((exp_q.size() < DEPTH) || pop);
    if (do_push && model_run) begin
      mem_model[int'(TOHOST)] = val;
      if (!ok) exp_ovf = 1;
    end
    if (pop) void'(exp_q.pop_front());
    if (ok) begin
      exp_q.push_back(val);
      if (val[0]) begin
        model_done = 1; model_run = 0; exp_exit = val[31:1];
      end
    end
    tick();
    ram_wr_en = 1'b0; tohost_ready = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) fifo_cycle(1'b0, '0, 1'($urandom_range(0, 1)));
    fifo_cycle(1'b0, '0, 1'b0);
  endtask

  // tests
  task automatic test_reset();
    reset_n = 1'b0;
    idle();
    repeat (3) tick();
    model_reset();
    n_cmp++;
    if ({core_reset_n, ld_ready, tohost_valid, tohost_ovf, done, load_err} !== 6'b010000) begin
      n_err++; $display("FAIL reset_flags: got %b want 010000",
                        {core_reset_n, ld_ready, tohost_valid, tohost_ovf, done, load_err});
    end
    n_cmp++;
    if (exit_code !== 31'd0) begin
      n_err++; $display("FAIL reset_exit: got %h want 0", exit_code);
    end
    reset_n = 1'b1;
    tick();
    n_cmp++;
    if ({core_reset_n, ld_ready} !== 2'b01) begin
      n_err++; $display("FAIL post_reset: core_reset_n,ld_ready=%b want 01", {core_reset_n, ld_ready});
    end
  endtask

  task automatic test_load();
    load_q.delete();
    load_q.push_back(32'h0000_0013);
    load_q.push_back(32'h0000_0013);
`ifdef RAM_LOAD_CHECKSUM_EN
    load_q.push_back(32'h0000_0026);
`else
    load_q.push_back(32'h0000_006F);
`endif
    load_image();
    ram_addr = 16'h4001;
    #1;
    n_cmp++;
    if (ram_data_out !== 32'h0000_0013) begin
      n_err++; $display("FAIL load_word1: got %h want 00000013", ram_data_out);
    end
`ifndef RAM_LOAD_CHECKSUM_EN
    ram_addr = 16'h4002;
    #1;
    n_cmp++;
    if (ram_data_out !== 32'h0000_006F) begin
      n_err++; $display("FAIL load_word2: got %h want 0000006f", ram_data_out);
    end
`endif
    verify_mem("load");
  endtask

  task automatic test_strobe_write();
    logic [15:0] a;
    core_write(16'h0100, 4'hF, 32'h1122_3344);
    core_write(16'h0100, 4'b0100, 32'h00AB_0000);
    ram_addr = 16'h0100;
    #1;
    n_cmp++;
    if (ram_data_out !== 32'h11AB_3344) begin
      n_err++; $display("FAIL strobe_lane2: got %h want 11ab3344", ram_data_out);
    end
    for (int i = 0; i < 8; i++) core_write(16'h0200 + 16'(i), 4'hF, $urandom);
    repeat (30) begin
      a = 16'h0200 + 16'($urandom_range(0, 7));
      core_write(a, 4'($urandom_range(0, 15)), $urandom);
      ram_addr = a;
      #1;
      n_cmp++;
      if (ram_data_out !== mem_model[int'(a)]) begin
        n_err++; $display("FAIL strobe_rand[%h]: got %h want %h", a, ram_data_out, mem_model[int'(a)]);
      end
    end
    // load port must stay closed while running
    core_write(ptr_model, 4'hF, 32'hCAFE_F00D);
    ld_valid = 1'b1; ld_data = 32'hDEAD_0001; ld_last = 1'b0;
    #1;
    n_cmp++;
    if (ld_ready !== 1'b0) begin
      n_err++; $display("FAIL ld_ready_run: got %b want 0", ld_ready);
    end
    tick();
    ld_valid = 1'b0;
    verify_mem("run");
  endtask

  task automatic test_tohost();
    logic [31:0] v;
    fifo_cycle(1'b1, 32'h0000_0002, 1'b0);
    fifo_cycle(1'b1, 32'h0000_0004, 1'b0);
    fifo_cycle(1'b0, '0, 1'b0);
    fifo_cycle(1'b0, '0, 1'b1);
    fifo_cycle(1'b0, '0, 1'b0);
    drain();
    // partial-strobe store of an odd value: memory only, no push, no done
    core_write(TOHOST, 4'b0011, 32'h0000_1235);
    fifo_cycle(1'b0, '0, 1'b0);
    verify_mem("tohost_partial");
    // overflow when full, then push+pop on a full FIFO
    for (int i = 0; i < 5; i++) fifo_cycle(1'b1, $urandom & 32'hFFFF_FFFE, 1'b0);
    fifo_cycle(1'b0, '0, 1'b0);
    fifo_cycle(1'b1, $urandom & 32'hFFFF_FFFE, 1'b1);
    fifo_cycle(1'b0, '0, 1'b0);
    drain();
    repeat (60) begin
      v = $urandom & 32'hFFFF_FFFE;
      fifo_cycle(1'($urandom_range(0, 1)), v, 1'($urandom_range(0, 1)));
    end
    drain();
  endtask

  task automatic test_done();
    fifo_cycle(1'b1, 32'h0000_0007, 1'b0);
    fifo_cycle(1'b0, '0, 1'b0);
    n_cmp++;
    if ({done, core_reset_n, exit_code} !== {1'b1, 1'b0, 31'd3}) begin
      n_err++; $display("FAIL done_exit: done,core_reset_n=%b%b exit=%h want 1 0 3", done, core_reset_n, exit_code);
    end
    core_write(16'h0100, 4'hF, 32'h5555_AAAA);
    fifo_cycle(1'b1, 32'h0000_0008, 1'b1);
    fifo_cycle(1'b0, '0, 1'b0);
    verify_mem("done");
  endtask

  task automatic test_reload();
    logic [31:0] v;
    test_reset();
    for (int i = 0; i < 2; i++) begin
      ld_valid = 1'b1; ld_data = $urandom; ld_last = 1'b0;
      tick();
      mem_model[int'(ptr_model)] = ld_data;
      ptr_model = ptr_model + 16'd1;
    end
    ld_valid = 1'b0;
    test_reset();
    build_image(6);
    load_image();
    verify_mem("reload");
    v = $urandom | 32'h1;
    fifo_cycle(1'b1, v, 1'b0);
    fifo_cycle(1'b0, '0, 1'b1);
    fifo_cycle(1'b0, '0, 1'b0);
  endtask

`ifdef RAM_LOAD_CHECKSUM_EN
  task automatic test_checksum();
    logic [31:0] beats [3];
    beats[0] = 32'h1; beats[1] = 32'h2; beats[2] = 32'h4;
    test_reset();
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1; ld_data = beats[i]; ld_last = (i == 2);
      tick();
      if (i != 2) mem_model[int'(ptr_model)] = beats[i];
      ptr_model = ptr_model + 16'd1;
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    repeat (2) begin
      n_cmp++;
      if ({load_err, core_reset_n, ld_ready} !== 3'b100) begin
        n_err++; $display("FAIL checksum_err: load_err,core_reset_n,ld_ready=%b want 100",
                          {load_err, core_reset_n, ld_ready});
      end
      tick();
    end
    test_reset();
    load_q.delete();
    load_q.push_back(32'h1); load_q.push_back(32'h2); load_q.push_back(32'h3);
    load_image();
    verify_mem("checksum");
  endtask
`endif

  initial begin
    reset_n = 1'b0;
    idle();
    model_reset();
    test_reset();
    test_load();
    test_strobe_write();
    test_tohost();
    test_done();
    test_reload();
`ifdef RAM_LOAD_CHECKSUM_EN
    test_checksum();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
